// File: rtl/jstk_pkg.sv
`default_nettype none
// ============================================================================
// jstk_pkg : shared constants, state encoding and tx frame builder
// Revision : 1.0
// ============================================================================
package jstk_pkg;

  localparam int         FRAME_BYTES   = 5;
  localparam int         FRAME_BITS    = 8 * FRAME_BYTES;
  localparam logic [5:0] FRAME_BITS_C  = 6'd40;
  localparam logic [5:0] LAST_BIT_C    = 6'd39;
  localparam logic [5:0] CMD_BITS_C    = 6'd8;
  localparam logic [5:0] CMD_PREFIX    = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

  // Byte 0 sits in the MSBs so the frame shifts out MSB first, byte by byte.
  function automatic logic [FRAME_BITS-1:0] build_tx_frame(
    input logic [9:0] xpos,
    input logic [9:0] ypos,
    input logic [2:0] btn
  );
    return {xpos[7:0], 6'b0, xpos[9:8], ypos[7:0], 6'b0, ypos[9:8], 5'b0, btn};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : 2-FF synchronizer with single-cycle rise/fall pulses
// Revision  : 1.0
// ============================================================================
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/jstk_spi_slave.sv
`default_nettype none
// ============================================================================
// jstk_spi_slave : oversampled SPI mode-0 slave returning a 5-byte joystick
//                  frame and decoding an LED command from the first rx byte
// Revision       : 1.0
// ============================================================================
module jstk_spi_slave
  import jstk_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [9:0] XPOS,
  input  logic [9:0] YPOS,
  input  logic [2:0] BTN,
  output logic [1:0] LED,
  output logic [7:0] RXCMD,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR
);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_sync;
  logic ss_rise;
  logic ss_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (CLK),
    .rst  (RST),
    .d    (SCLK),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk  (CLK),
    .rst  (RST),
    .d    (SS),
    .q    (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  logic mosi_meta_q;
  logic mosi_sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  state_e                state_q,    state_d;
  logic [5:0]            bit_cnt_q,  bit_cnt_d;
  logic [7:0]            rx_byte_q,  rx_byte_d;
  logic [FRAME_BITS-1:0] tx_frame_q, tx_frame_d;
  logic                  miso_q,     miso_d;
  logic [1:0]            led_q,      led_d;
  logic [7:0]            rxcmd_q,    rxcmd_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic [1:0]            settle_q,   settle_d;
  logic                  armed_q,    armed_d;

  logic [FRAME_BITS-1:0] snap_frame;
  logic [5:0]            tx_idx;
  logic                  frame_end;

  assign snap_frame = build_tx_frame(XPOS, YPOS, BTN);
  assign tx_idx     = LAST_BIT_C - bit_cnt_q;

  // Sync chains restart at the idle level on reset, so an SS already low at
  // release looks like a fall; only arm once a settled high level is seen.
  always_comb begin
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd3) & ss_sync);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_byte_d  = rx_byte_q;
    tx_frame_d = tx_frame_q;
    miso_d     = miso_q;
    led_d      = led_q;
    rxcmd_d    = rxcmd_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall && armed_q) begin
          state_d    = ST_ACTIVE;
          tx_frame_d = snap_frame;
          bit_cnt_d  = 6'd0;
          rx_byte_d  = 8'h00;
          miso_d     = snap_frame[FRAME_BITS-1];
        end
      end

      ST_ACTIVE: begin
        if (ss_rise) begin
          frame_end = 1'b1;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q < CMD_BITS_C) begin
            rx_byte_d = {rx_byte_q[6:0], mosi_sync_q};
          end
          if (bit_cnt_q == LAST_BIT_C) begin
            state_d = ST_OVERRUN;
            miso_d  = 1'b0;
          end
        end else if (sclk_fall) begin
          miso_d = tx_frame_q[tx_idx];
        end
      end

      ST_OVERRUN: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          frame_end = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    if (frame_end) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      if (bit_cnt_q == FRAME_BITS_C) begin
        done_d  = 1'b1;
        rxcmd_d = rx_byte_q;
        if (rx_byte_q[7:2] == CMD_PREFIX) begin
          led_d = rx_byte_q[1:0];
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 6'd0;
      rx_byte_q  <= 8'h00;
      tx_frame_q <= '0;
      miso_q     <= 1'b0;
      led_q      <= 2'b00;
      rxcmd_q    <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_byte_q  <= rx_byte_d;
      tx_frame_q <= tx_frame_d;
      miso_q     <= miso_d;
      led_q      <= led_d;
      rxcmd_q    <= rxcmd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  assign MISO       = miso_q;
  assign MISO_OE    = ~ss_sync;
  assign LED        = led_q;
  assign RXCMD      = rxcmd_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jstk_spi_slave.sv
`default_nettype none
// ============================================================================
// tb_jstk_spi_slave : SPI master driver with a byte-level reference model
// Revision          : 1.0
// ============================================================================
module tb_jstk_spi_slave;

  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SCLK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic       MISO_OE;
  logic [9:0] XPOS;
  logic [9:0] YPOS;
  logic [2:0] BTN;
  logic [1:0] LED;
  logic [7:0] RXCMD;
  logic       FRAME_DONE;
  logic       FRAME_ERR;

  jstk_spi_slave dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCLK       (SCLK),
    .SS         (SS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .MISO_OE    (MISO_OE),
    .XPOS       (XPOS),
    .YPOS       (YPOS),
    .BTN        (BTN),
    .LED        (LED),
    .RXCMD      (RXCMD),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [1:0] mdl_led   = 2'b00;
  logic [7:0] mdl_rxcmd = 8'h00;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cnt++;
    if (FRAME_ERR === 1'b1)  err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One SS-low window of nbits SCLK cycles; optional mid-frame XPOS change and RST pulse.
  task automatic run_frame(input logic [39:0] mosi_bits, input int nbits,
                           input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                           input int xchg_bit, input logic [9:0] xnew, input int rst_bit);
    logic [7:0] exp_b [5];
    logic       seen [48];
    logic [7:0] gb;
    logic       over_or;
    int         d0, e0, full_bytes;
    bit         aborted;

    XPOS = x; YPOS = y; BTN = b;
    exp_b[0] = x[7:0];
    exp_b[1] = 8'(x >> 8);
    exp_b[2] = y[7:0];
    exp_b[3] = 8'(y >> 8);
    exp_b[4] = 8'(b);
    aborted  = 1'b0;
    over_or  = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;

    wait_clks(2);
    SS = 1'b0;
    wait_clks(HALF);
    check("miso_oe_active", MISO_OE, 1'b1);
    for (int k = 0; k < nbits; k++) begin
      if (k == xchg_bit) XPOS = xnew;
      if (k == rst_bit) begin
        RST = 1'b1;
        wait_clks(3);
        RST = 1'b0;
        aborted = 1'b1;
      end
      MOSI = (k < 40) ? mosi_bits[39-k] : 1'($urandom);
      wait_clks(HALF);
      seen[k] = MISO;
      if (k >= 40) over_or = over_or | MISO;
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
    end
    wait_clks(HALF);
    SS = 1'b1;
    wait_clks(10);
    check("miso_oe_idle", MISO_OE, 1'b0);
    check("miso_idle", MISO, 1'b0);

    if (aborted) begin
      mdl_led   = 2'b00;
      mdl_rxcmd = 8'h00;
      check("done_pulses", done_cnt - d0, 0);
      check("err_pulses", err_cnt - e0, 0);
    end else begin
      if (nbits >= 40) begin
        mdl_rxcmd = mosi_bits[39:32];
        if (mosi_bits[39:34] == 6'b100000) mdl_led = mosi_bits[33:32];
        check("done_pulses", done_cnt - d0, 1);
        check("err_pulses", err_cnt - e0, 0);
      end else begin
        check("done_pulses", done_cnt - d0, 0);
        check("err_pulses", err_cnt - e0, 1);
      end
      full_bytes = (nbits >= 40) ? 5 : nbits / 8;
      for (int i = 0; i < full_bytes; i++) begin
        gb = 8'h00;
        for (int j = 0; j < 8; j++) gb = {gb[6:0], seen[8*i+j]};
        check($sformatf("miso_byte%0d", i), gb, exp_b[i]);
      end
      if (nbits > 40) check("miso_overrun_zero", over_or, 1'b0);
    end
    check("led", LED, mdl_led);
    check("rxcmd", RXCMD, mdl_rxcmd);
  endtask

  initial begin
    logic [39:0] bits;
    logic [7:0]  cmd;
    int          n, sel;

    RST = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    XPOS = '0; YPOS = '0; BTN = '0;
    wait_clks(4);
    check("rst_miso", MISO, 1'b0);
    check("rst_miso_oe", MISO_OE, 1'b0);
    check("rst_led", LED, 2'b00);
    check("rst_rxcmd", RXCMD, 8'h00);
    check("rst_done", FRAME_DONE, 1'b0);
    check("rst_err", FRAME_ERR, 1'b0);
    RST = 1'b0;
    wait_clks(10);

    run_frame({8'h83, 32'h0}, 40, 10'h2A5, 10'h13C, 3'b101, -1, 10'h0, -1);
    run_frame({8'h00, 32'h0}, 40, 10'h155, 10'h2AA, 3'b010, -1, 10'h0, -1);
    run_frame({8'h82, 32'h0}, 17, 10'h111, 10'h222, 3'b011, -1, 10'h0, -1);
    run_frame({8'h81, 32'hDEADBEEF}, 48, 10'h3C3, 10'h0F0, 3'b110, -1, 10'h0, -1);
    run_frame({8'h80, 32'h0}, 40, 10'h000, 10'h155, 3'b001, 3, 10'h3FF, -1);
    run_frame({8'h83, 32'h0}, 40, 10'h0AA, 10'h055, 3'b111, -1, 10'h0, 20);
    run_frame({8'h82, 32'h12345678}, 40, 10'h1FE, 10'h201, 3'b100, -1, 10'h0, -1);
    run_frame({8'h81, 32'h0}, 0, 10'h001, 10'h002, 3'b000, -1, 10'h0, -1);

    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 3));
      cmd = ($urandom_range(0, 1) == 1) ? {6'b100000, 2'($urandom)} : 8'($urandom);
      bits = {cmd, 32'($urandom)};
      n = (sel == 0) ? int'($urandom_range(0, 39)) :
          (sel == 1) ? int'($urandom_range(41, 48)) : 40;
      run_frame(bits, n, 10'($urandom), 10'($urandom), 3'($urandom), -1, 10'h0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jstk_spi_slave.md
JSTK_SPI_SLAVE -- requirements
Module: jstk_spi_slave

Interface
REQ-001 SHALL have port CLK  input  1  system clock; oversamples SPI, >= 8x SCLK frequency.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port SCLK  input  1  SPI clock from master; mode 0, idle low.
REQ-004 SHALL have port SS  input  1  slave select from master, active low.
REQ-005 SHALL have port MOSI  input  1  master-out data, MSB first.
REQ-006 SHALL have port MISO  output  1  slave-out data, MSB first.
REQ-007 SHALL have port MISO_OE  output  1  MISO drive enable; high while the synchronized SS is low.
REQ-008 SHALL have port XPOS  input  10  joystick X position.
REQ-009 SHALL have port YPOS  input  10  joystick Y position.
REQ-010 SHALL have port BTN  input  3  buttons {btn2, btn1, stick}.
REQ-011 SHALL have port LED  output  2  LED state from the last valid command.
REQ-012 SHALL have port RXCMD  output  8  first byte received in the last complete frame.
REQ-013 SHALL have port FRAME_DONE  output  1  one-cycle pulse when a complete 5-byte frame ends.
REQ-014 SHALL have port FRAME_ERR  output  1  one-cycle pulse when SS rises before 40 bits are received.

Function
REQ-015 SHALL pass SCLK, SS and MOSI through 2-FF synchronizers; SCLK and SS edges are detected on the synchronized signals.
REQ-016 SHALL implement FSM states IDLE, ACTIVE and OVERRUN.
- IDLE -> ACTIVE on SS falling edge.
- ACTIVE -> OVERRUN after bit 40 is sampled.
- ACTIVE/OVERRUN -> IDLE on SS rising edge.
REQ-017 SHALL, on SS falling edge, snapshot the tx frame as byte0={XPOS[7:0]}, byte1={6'b0,XPOS[9:8]}, byte2={YPOS[7:0]}, byte3={6'b0,YPOS[9:8]}, byte4={5'b0,BTN}; the frame is held constant until the next SS fall.
REQ-018 SHALL present byte0 bit7 on MISO in the cycle after the SS fall is detected, i.e. before the first SCLK rise.
REQ-019 SHALL sample MOSI on each synchronized SCLK rising edge in ACTIVE and increment a 6-bit bit counter (0..40).
REQ-020 SHALL advance MISO to the next tx bit on each synchronized SCLK falling edge in ACTIVE, crossing byte boundaries without gaps.
REQ-021 SHALL ignore SCLK edges in IDLE and OVERRUN; MISO holds 0 in OVERRUN.
REQ-022 SHALL, on SS rise with bit count == 40, pulse FRAME_DONE and load RXCMD with rx byte0.
REQ-023 SHALL, in the same FRAME_DONE cycle, load LED with rx byte0[1:0] when rx byte0[7:2] == 6'b100000; otherwise LED is unchanged.
REQ-024 SHALL, on SS rise with bit count < 40 (including 0), pulse FRAME_ERR and leave LED and RXCMD unchanged.
REQ-025 SHALL treat an SS rise and an SCLK edge detected in the same cycle as SS rise only.
REQ-026 SHALL drive MISO to 0 in IDLE.

Reset
REQ-027 SHALL, while RST is high, set the following to their reset values and enter IDLE:
- MISO=0, MISO_OE=0, LED=2'b00, RXCMD=8'h00, FRAME_DONE=0, FRAME_ERR=0;
- bit counter=0, shift registers=0, synchronizers=idle (SCLK 0, SS 1).
REQ-028 SHALL, after reset is released mid-frame with SS low, ignore the frame until SS goes high and then low again; no pulse is produced for the aborted frame.

Structure
REQ-029 SHALL place in shared package jstk_pkg:
- frame length constants (5 bytes, 40 bits);
- command prefix 6'b100000;
- FSM state encoding.
REQ-030 SHALL instantiate sub-module sync_edge (2-FF synchronizer with rise/fall pulse outputs) once each for SCLK and SS; MOSI uses the synchronizer only.

Verification
REQ-031 SHALL verify a full frame:
- stimulus: XPOS=10'h2A5, YPOS=10'h13C, BTN=3'b101; master sends 8'h83,00,00,00,00;
- required response: MISO bytes A5,02,3C,01,05; LED=2'b11; RXCMD=8'h83; one FRAME_DONE pulse.
REQ-032 SHALL verify a non-command frame: master sends 8'h00 as byte0 -> LED unchanged, RXCMD=8'h00, FRAME_DONE pulses.
REQ-033 SHALL verify an aborted frame: SS rises after 17 bits -> FRAME_ERR pulses once; FRAME_DONE=0; LED and RXCMD unchanged.
REQ-034 SHALL verify overrun: 48 SCLK cycles within one SS-low window -> MISO=0 after bit 40; FRAME_DONE on SS rise; RXCMD is taken from the first 8 bits.
REQ-035 SHALL verify the snapshot: XPOS changes from 10'h000 to 10'h3FF mid-frame -> returned X bytes are 00,00.
REQ-036 SHALL verify reset mid-frame: RST pulses at bit 20 -> no pulses; the next full frame completes normally with FRAME_DONE.
